// File: rtl/mem_pipe_responder.sv
// Pipelined memory responder: single-cycle request acceptance, reads returned
// after a fixed LATENCY through a valid/data shift pipeline, in request order.
module mem_pipe_responder #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid
);

    // A 16-bit byte address only carries 15 word-index bits; wider arrays
    // simply leave their upper half unreachable.
    localparam int IDX_HI = (ADDR_W < 15) ? ADDR_W : 15;

    logic [15:0]                  mem [2**ADDR_W];
    logic [ADDR_W-1:0]            idx;
    logic                         rd_req;
    logic [15:0]                  rd_word;
    logic [LATENCY-1:0]           vld_pipe;
    logic [LATENCY-1:0][15:0]     dat_pipe;
    logic                         unused_addr;

    assign idx         = ADDR_W'(addr[IDX_HI:1]);
    assign unused_addr = ^addr;
    assign rd_req      = enable & ~wr;
    assign rd_word     = mem[idx];

    // Array is not reset; writes are simply blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && enable && wr)
            mem[idx] <= data_in;
    end

    // Stage 0 samples the array at the accepting edge; the last stage is the
    // output register and only loads when a valid entry arrives, else holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_req;
            if (LATENCY > 1 || rd_req)
                dat_pipe[0] <= rd_word;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (i < LATENCY - 1 || vld_pipe[i-1])
                    dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign data_valid = vld_pipe[LATENCY-1];
    assign data_out   = dat_pipe[LATENCY-1];

endmodule
